// File: rtl/score_digit_renderer.sv
// Purpose : overlays an N-digit BCD score (5x7 font, 2^SCALE_LOG2 pixel scaling) at a fixed screen position.
// Latency : pixel_on is registered exactly 2 cycles after the hcount/vcount it describes.
// Backpressure: none; one pixel is accepted every cycle and the pipeline never stalls.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous active-high reset
//   hcount       current pixel column (11 bits)
//   vcount       current pixel row (10 bits)
//   frame_start  one-cycle pulse; latches score_bcd into the shadow register
//   score_bcd    BCD score, nibble [3:0] is the least significant (rightmost) digit
//   pixel_on     1 = glyph foreground for the pixel presented 2 cycles earlier
module score_digit_renderer #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCALE_LOG2    = 1,
  parameter int X0            = 500,
  parameter int Y0            = 16,
  parameter int DIGIT_GAP     = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [10:0]             hcount,
  input  logic [9:0]              vcount,
  input  logic                    frame_start,
  input  logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    pixel_on
);

  localparam int CELL_W  = (5 + DIGIT_GAP) << SCALE_LOG2;
  localparam int GLYPH_H = 7 << SCALE_LOG2;

  // Mask matching an all-zero shadow: every digit except the last is blanked.
  localparam logic [NUM_DIGITS-1:0] RST_MASK =
    (BLANK_LEADING != 0) ? ({NUM_DIGITS{1'b1}} >> 1) : '0;

  // Rows of the 5x7 font; row 0 sits in the top five bits.
  function automatic logic [4:0] glyph_row(input logic [3:0] code, input logic [2:0] row);
    logic [34:0] g;
    logic [4:0]  r;
    case (code)
      4'd0:    g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'd1:    g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'd2:    g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'd3:    g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'd4:    g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'd5:    g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'd6:    g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'd7:    g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'd8:    g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'd9:    g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      default: g = {7{5'h1F}};  // non-BCD code: solid block flags the fault
    endcase
    case (row)
      3'd0:    r = g[34:30];
      3'd1:    r = g[29:25];
      3'd2:    r = g[24:20];
      3'd3:    r = g[19:15];
      3'd4:    r = g[14:10];
      3'd5:    r = g[9:5];
      3'd6:    r = g[4:0];
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // ---------------- frame-latched score and blank mask ----------------
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blank_next;
  logic                    zero_run;

  // Digit i is blanked while every digit from the left edge up to i is zero.
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run & (score_bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if ((BLANK_LEADING != 0) && (i < NUM_DIGITS - 1)) begin
        blank_next[i] = zero_run;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      blank_mask <= RST_MASK;
    end else if (frame_start) begin
      shadow     <= score_bcd;
      blank_mask <= blank_next;
    end
  end

  // ---------------- stage 1: locate the pixel inside the field ----------------
  int         hx;
  int         vy;
  logic       hit_c;
  logic       row_ok_c;
  logic       in_box_c;
  logic [2:0] col_c;
  logic [2:0] row_c;
  logic [3:0] code_c;
  logic       blank_c;

  // One constant-bound range compare per digit; at most one can hit.
  always_comb begin
    hx       = int'(hcount);
    vy       = int'(vcount);
    hit_c    = 1'b0;
    col_c    = 3'd0;
    code_c   = 4'd0;
    blank_c  = 1'b0;
    row_ok_c = (vy >= Y0) && (vy < Y0 + GLYPH_H);
    row_c    = 3'((vy - Y0) >> SCALE_LOG2);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((hx >= X0 + i*CELL_W) && (hx < X0 + (i+1)*CELL_W)) begin
        hit_c   = 1'b1;
        col_c   = 3'((hx - X0 - i*CELL_W) >> SCALE_LOG2);
        code_c  = shadow[4*(NUM_DIGITS-1-i) +: 4];
        blank_c = blank_mask[i];
      end
    end
    // Font columns 5 and up are the inter-digit gap.
    in_box_c = hit_c && row_ok_c && (col_c < 3'd5);
  end

  logic       in_box_q;
  logic [2:0] col_q;
  logic [2:0] row_q;
  logic [3:0] code_q;
  logic       blank_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_box_q <= 1'b0;
      col_q    <= 3'd0;
      row_q    <= 3'd0;
      code_q   <= 4'd0;
      blank_q  <= 1'b0;
    end else begin
      in_box_q <= in_box_c;
      col_q    <= col_c;
      row_q    <= row_c;
      code_q   <= code_c;
      blank_q  <= blank_c;
    end
  end

  // ---------------- stage 2: font lookup ----------------
  logic [4:0] glyph_bits;
  logic       glyph_bit;

  // Font column 0 is the leftmost pixel, held in bit 4 of the row.
  always_comb begin
    glyph_bits = glyph_row(code_q, row_q);
    glyph_bit  = 1'b0;
    case (col_q)
      3'd0:    glyph_bit = glyph_bits[4];
      3'd1:    glyph_bit = glyph_bits[3];
      3'd2:    glyph_bit = glyph_bits[2];
      3'd3:    glyph_bit = glyph_bits[1];
      3'd4:    glyph_bit = glyph_bits[0];
      default: glyph_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= in_box_q & ~blank_q & glyph_bit;
    end
  end

endmodule
